// File: rtl/cordic_iter_sequencer_if.sv
// cordic_iter_sequencer_if: request/strobe bundle between the CORDIC sequencer and its requester/datapath.
interface cordic_iter_sequencer_if #(parameter int IDX_W = 5);
  logic start, dp_ready, z_sign, angle_gt_half_pi, angle_lt_neg_half_pi;
  logic busy, load_signal, fold_signal, fold_dir, iter_en, rot_dir, scale_signal, done;
  logic [IDX_W-1:0] iter_idx;
  modport master (
    output start, dp_ready, z_sign, angle_gt_half_pi, angle_lt_neg_half_pi,
    input  busy, load_signal, fold_signal, fold_dir, iter_en, iter_idx, rot_dir, scale_signal, done
  );
  modport slave (
    input  start, dp_ready, z_sign, angle_gt_half_pi, angle_lt_neg_half_pi,
    output busy, load_signal, fold_signal, fold_dir, iter_en, iter_idx, rot_dir, scale_signal, done
  );
endinterface

// File: rtl/cordic_iter_sequencer.sv
// cordic_iter_sequencer: drives load, optional quadrant fold, ITER micro-rotations and K scaling.
// Define CORDIC_SEQ_QUAD_FOLD_EN to include the FOLD state (convergence over +/-pi).
module cordic_iter_sequencer #(
  parameter int ITER  = 16,
  parameter int IDX_W = 5
) (
  input logic clk,
  input logic start_restart_n,
  cordic_iter_sequencer_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FOLD, S_ITER, S_SCALE, S_DONE} state_t;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(ITER - 1);
  state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic busy_q, busy_d, load_q, load_d, fold_q, fold_d, dir_q, dir_d, done_q, done_d;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_LOAD;
`ifdef CORDIC_SEQ_QUAD_FOLD_EN
      S_LOAD:  state_d = S_FOLD;
`else
      S_LOAD:  state_d = S_ITER;
`endif
      S_FOLD:  state_d = S_ITER;
      S_ITER:  if (bus.dp_ready) begin
        if (idx_q == LAST) state_d = S_SCALE;
        else idx_d = idx_q + 1'b1;
      end
      S_SCALE: if (bus.dp_ready) state_d = S_DONE;
      S_DONE:  begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = state_d inside {S_LOAD, S_FOLD, S_ITER, S_SCALE};
    load_d = state_d == S_LOAD;
    done_d = state_d == S_DONE;
`ifdef CORDIC_SEQ_QUAD_FOLD_EN
    // comparators are sampled during LOAD so the fold strobe is a registered output of FOLD
    fold_d = state_d == S_FOLD && (bus.angle_gt_half_pi || bus.angle_lt_neg_half_pi);
    dir_d  = state_d == S_FOLD && !bus.angle_gt_half_pi && bus.angle_lt_neg_half_pi;
`else
    fold_d = 1'b0;
    dir_d  = 1'b0;
`endif
  end
`ifndef CORDIC_SEQ_QUAD_FOLD_EN
  logic unused_cmp;
  assign unused_cmp = bus.angle_gt_half_pi ^ bus.angle_lt_neg_half_pi;
`endif
  always_ff @(posedge clk or negedge start_restart_n) begin
    if (!start_restart_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      load_q  <= 1'b0;
      fold_q  <= 1'b0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      load_q  <= load_d;
      fold_q  <= fold_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end
  // step strobes follow dp_ready within the cycle so a stall suppresses them immediately
  assign bus.iter_en      = state_q == S_ITER && bus.dp_ready;
  assign bus.scale_signal = state_q == S_SCALE && bus.dp_ready;
  assign bus.rot_dir      = state_q == S_ITER && !bus.z_sign;
  assign bus.iter_idx     = idx_q;
  assign bus.busy         = busy_q;
  assign bus.load_signal  = load_q;
  assign bus.fold_signal  = fold_q;
  assign bus.fold_dir     = dir_q;
  assign bus.done         = done_q;
endmodule

// File: tb/tb_cordic_iter_sequencer.sv
// tb_cordic_iter_sequencer: cycle-level check of the CORDIC sequencer against a ready-count model.
module tb_cordic_iter_sequencer;
  localparam int ITER = 16, IDX_W = 5, ITER4 = 4, IDX4 = 3;
`ifdef CORDIC_SEQ_QUAD_FOLD_EN
  localparam int FOLD = 1;
`else
  localparam int FOLD = 0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  int n_cmp = 0, n_bad = 0;
  cordic_iter_sequencer_if #(.IDX_W(IDX_W)) bus ();
  cordic_iter_sequencer_if #(.IDX_W(IDX4)) bus4 ();
  cordic_iter_sequencer #(.ITER(ITER), .IDX_W(IDX_W)) dut (.clk(clk), .start_restart_n(rst_n), .bus(bus));
  cordic_iter_sequencer #(.ITER(ITER4), .IDX_W(IDX4)) dut4 (.clk(clk), .start_restart_n(rst_n), .bus(bus4));
  always #5 clk = ~clk;

  function automatic logic [12:0] pack(logic b, l, f, d, ie, logic [IDX_W-1:0] idx, logic r, s, dn);
    return {b, l, f, d, ie, idx, r, s, dn};
  endfunction
  function automatic logic [12:0] observe();
    return {bus.busy, bus.load_signal, bus.fold_signal, bus.fold_dir, bus.iter_en,
            bus.iter_idx, bus.rot_dir, bus.scale_signal, bus.done};
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Model: after LOAD (and FOLD) the op needs ITER+1 ready cycles; the k-th ready cycle
  // rotates with index k for k<ITER, the last one scales, and DONE follows.
  task automatic run_op(input int stall_pct, input int stall_at, input int stall_len,
                        input logic gt, input logic lt, output int done_cyc);
    int consumed = 0, stall_left = stall_len;
    logic rdy, z;
    logic [12:0] exp, mask;
    done_cyc = -1;
    bus.start = 1'b1;
    bus.angle_gt_half_pi = gt;
    bus.angle_lt_neg_half_pi = lt;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int cyc = 1; cyc < 400 && done_cyc < 0; cyc++) begin
      rdy = stall_at >= 0 ? !(consumed == stall_at && stall_left > 0) : ($urandom_range(99) >= stall_pct);
      z = 1'($urandom);
      bus.dp_ready = rdy;
      bus.z_sign = z;
      mask = '1;
      if (cyc == 1) exp = pack(1, 1, 0, 0, 0, '0, 0, 0, 0);
      else if (FOLD == 1 && cyc == 2) exp = pack(1, 0, gt | lt, !gt && lt, 0, '0, 0, 0, 0);
      else if (consumed < ITER) exp = pack(1, 0, 0, 0, rdy, IDX_W'(consumed), !z, 0, 0);
      else if (consumed == ITER) exp = pack(1, 0, 0, 0, 0, IDX_W'(ITER - 1), 0, rdy, 0);
      else begin
        exp = pack(0, 0, 0, 0, 0, '0, 0, 0, 1);
        mask = pack(1, 1, 1, 1, 1, '0, 1, 1, 1);
        done_cyc = cyc;
      end
      @(negedge clk);
      check($sformatf("cycle%0d", cyc), 32'(observe() & mask), 32'(exp));
      if (cyc > 1 + FOLD && consumed <= ITER) begin
        if (rdy) consumed++;
        else stall_left--;
      end
      @(posedge clk); #1;
    end
    bus.dp_ready = 1'b0;
    @(negedge clk);
    check("idle_after_done", 32'(observe()), 32'(0));
  endtask

  initial begin
    int d, seen;
    int q_done[$];
    int exp_done[$];
    {bus.start, bus.dp_ready, bus.z_sign, bus.angle_gt_half_pi, bus.angle_lt_neg_half_pi} = '0;
    {bus4.start, bus4.dp_ready, bus4.z_sign, bus4.angle_gt_half_pi, bus4.angle_lt_neg_half_pi} = '0;
    #1;
    check("reset_outputs", 32'(observe()), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);

    run_op(0, -1, 0, 1'b0, 1'b0, d);
    check("done_cycle_nostall", d, ITER + 3 + FOLD);
    run_op(0, 5, 3, 1'b0, 1'b0, d);
    check("done_cycle_stall3", d, ITER + 6 + FOLD);
`ifdef CORDIC_SEQ_QUAD_FOLD_EN
    run_op(0, -1, 0, 1'b1, 1'b0, d);
    check("done_cycle_fold_gt", d, ITER + 4);
    run_op(0, -1, 0, 1'b1, 1'b1, d);
    run_op(0, -1, 0, 1'b0, 1'b0, d);
    run_op(0, -1, 0, 1'b0, 1'b1, d);
`endif
    repeat (8) run_op(30, -1, 0, 1'($urandom), 1'($urandom), d);

    // asynchronous reset in the middle of the rotations
    bus.start = 1'b1;
    bus.dp_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    seen = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      @(negedge clk);
      if (bus.iter_en && bus.iter_idx == IDX_W'(8)) seen = 1;
    end
    check("reached_idx8", seen, 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'(observe()), 32'(0));
    check("async_reset_outputs4", 32'({bus4.busy, bus4.iter_en, bus4.iter_idx, bus4.done}), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    check("no_done_after_abort", seen, 0);
    run_op(0, -1, 0, 1'b0, 1'b0, d);
    check("done_cycle_after_reset", d, ITER + 3 + FOLD);

    // start held high for 40 edges on the ITER=4 instance
    bus4.start = 1'b1;
    bus4.dp_ready = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      @(posedge clk); #1;
      if (c == 40) bus4.start = 1'b0;
      @(negedge clk);
      if (bus4.done) q_done.push_back(c);
    end
    for (int s = 0; s <= 39; s += ITER4 + 4) exp_done.push_back(s + ITER4 + 3);
    check("held_start_done_count", q_done.size(), exp_done.size());
    for (int k = 0; k < exp_done.size() && k < q_done.size(); k++)
      check($sformatf("held_start_done%0d", k), q_done[k], exp_done[k]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
